stream_arbiter: RTL

//   Round-robin arbiter sharing one 32-bit stb/ack output stream (e.g. rs232_tx)

---
 rtl/stream_arbiter_if.sv | 36 +++
 rtl/stream_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/stream_arbiter_if.sv
// Handshake bundle between N producer streams, the stream arbiter and one sink.
// The arbiter takes the master view; producers and the sink take the slave view.
interface stream_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 32
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;

  logic [N*WIDTH-1:0] input_in;
  logic [N-1:0]       input_in_stb;
  logic [N-1:0]       input_in_ack;
  logic [WIDTH-1:0]   output_out;
  logic               output_out_stb;
  logic               output_out_ack;
  logic [GW-1:0]      output_grant;

  modport master (
    input  input_in,
    input  input_in_stb,
    output input_in_ack,
    output output_out,
    output output_out_stb,
    input  output_out_ack,
    output output_grant
  );

  modport slave (
    output input_in,
    output input_in_stb,
    input  input_in_ack,
    input  output_out,
    input  output_out_stb,
    output output_out_ack,
    input  output_grant
  );
endinterface

// File: rtl/stream_arbiter.sv
// Round-robin arbiter multiplexing N stb/ack producer streams onto one registered
// output stream, with bounded per-requester bursts and a sticky sink-stall flag.
module stream_arbiter #(
  parameter int N         = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 1024
) (
  input  logic             clk,
  input  logic             rst,
  output logic             exception,
  stream_arbiter_if.master bus
);
  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [GW-1:0] LAST_RST   = GW'(N - 1);
  localparam logic [BW-1:0] BURST_MAX  = BW'(MAX_BURST);
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  typedef enum logic {
    ARB  = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [GW-1:0]    last_q,  last_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic             hold_q,  hold_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             exc_q,   exc_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             stb_q,   stb_d;
  logic [GW-1:0]    grant_q, grant_d;

  logic             sel_valid;
  logic             sel_cont;
  logic [GW-1:0]    sel_idx;
  logic [GW-1:0]    cand;
  logic [WIDTH-1:0] sel_word;
  logic [N-1:0]     ack_vec;

  // Requester selection: continue the current burst, else round-robin after last_q.
  always_comb begin
    sel_valid = 1'b0;
    sel_cont  = 1'b0;
    sel_idx   = last_q;
    cand      = last_q;
    if (hold_q && bus.input_in_stb[last_q]) begin
      sel_valid = 1'b1;
      sel_cont  = 1'b1;
    end else begin
      // Scanning from the farthest candidate back lets the nearest active one win.
      for (int i = N; i >= 1; i--) begin
        cand = GW'((int'(last_q) + i) % N);
        if (bus.input_in_stb[cand]) begin
          sel_valid = 1'b1;
          sel_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    sel_word = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_idx == GW'(k)) sel_word = bus.input_in[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    // NOTE: every signal gets its default first, so no path leaves one unassigned (no latch).
    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_q;
    hold_d  = hold_q;
    timer_d = timer_q;
    exc_d   = exc_q;
    data_d  = data_q;
    stb_d   = stb_q;
    grant_d = grant_q;
    ack_vec = '0;

    unique case (state_q)
      ARB: begin
        if (sel_valid) begin
          for (int k = 0; k < N; k++) ack_vec[k] = (sel_idx == GW'(k));
          data_d  = sel_word;
          stb_d   = 1'b1;
          grant_d = sel_idx;
          last_d  = sel_idx;
          burst_d = sel_cont ? burst_q + 1'b1 : BW'(1);
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.output_out_ack) begin
          stb_d   = 1'b0;
          timer_d = '0;
          hold_d  = (burst_q < BURST_MAX);
          state_d = ARB;
        end else begin
          if (timer_q != '1) timer_d = timer_q + 1'b1;
          if (TIMEOUT != 0 && timer_q == TIMER_LAST) exc_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments make every register sample pre-edge values.
    if (rst) begin
      state_q <= ARB;
      last_q  <= LAST_RST;
      burst_q <= '0;
      hold_q  <= 1'b0;
      timer_q <= '0;
      exc_q   <= 1'b0;
      data_q  <= '0;
      stb_q   <= 1'b0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      burst_q <= burst_d;
      hold_q  <= hold_d;
      timer_q <= timer_d;
      exc_q   <= exc_d;
      data_q  <= data_d;
      stb_q   <= stb_d;
      grant_q <= grant_d;
    end
  end

  // Accept pulses are suppressed while rst is high so no word is taken during reset.
  assign bus.input_in_ack   = rst ? '0 : ack_vec;
  assign bus.output_out     = data_q;
  assign bus.output_out_stb = stb_q;
  assign bus.output_grant   = grant_q;
  assign exception          = exc_q;
endmodule
